// File: rtl/vram_blit_engine.sv
// VRAM blit engine: full-buffer FILL and row SCROLL for a text display.
// The CPU owns the VRAM port whenever it asks; the engine uses idle cycles.
module vram_blit_engine #(
  parameter int COLS_WORDS = 80,
  parameter int ROWS       = 45,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  cpu_req_in,
  input  logic [31:0]           cpu_addr_in,
  input  logic [31:0]           cpu_data_in,
  input  logic [3:0]            cpu_write_enable_in,
  output logic [31:0]           cpu_data_out,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic                  cmd_op_in,
  input  logic [5:0]            cmd_rows_in,
  input  logic [31:0]           cmd_fill_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [ADDR_WIDTH-1:0] vram_addr_out,
  output logic [31:0]           vram_data_out,
  output logic [3:0]            vram_write_enable_out,
  input  logic [31:0]           vram_data_in
);

  localparam int AW    = ADDR_WIDTH;
  localparam int TOTAL = COLS_WORDS * ROWS;
  localparam logic [AW-1:0] LAST = AW'(TOTAL - 1);
  localparam logic [7:0] WLAST = 8'(RD_LATENCY - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FILL = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] shift_q, shift_d;
  logic [AW-1:0] clast_q, clast_d;
  logic [31:0]   fill_q, fill_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    wcnt_q, wcnt_d;

  logic [AW-1:0] eng_addr;
  logic [31:0]   eng_data;
  logic [3:0]    eng_we;

  int            rows_i;
  logic          rows_big;
  logic          is_fill;
  logic          is_none;
  logic          is_copy;
  logic [AW-1:0] shift_new;
  logic [AW-1:0] clast_new;

  assign rows_i    = int'(cmd_rows_in);
  assign rows_big  = rows_i >= ROWS;
  assign is_fill   = !cmd_op_in || rows_big;
  assign is_none   = cmd_op_in && cmd_rows_in == 6'd0;
  assign is_copy   = cmd_op_in && !rows_big &&
                     cmd_rows_in != 6'd0;
  assign shift_new = AW'(rows_i * COLS_WORDS);
  // last copy destination; only meaningful for 0 < rows < ROWS
  assign clast_new = AW'(TOTAL - 1 - rows_i * COLS_WORDS);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    clast_d  = clast_q;
    fill_d   = fill_q;
    data_d   = data_q;
    wcnt_d   = wcnt_q;
    eng_addr = idx_q;
    eng_data = fill_q;
    eng_we   = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          fill_d  = cmd_fill_in;
          idx_d   = '0;
          shift_d = shift_new;
          clast_d = clast_new;
          unique case (1'b1)
            is_fill: state_d = S_FILL;
            is_none: state_d = S_DONE;
            is_copy: state_d = S_RD;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RD: begin
        eng_addr = idx_q + shift_q;
        if (!cpu_req_in) begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // read data lands RD_LATENCY cycles after the RD cycle
        if (wcnt_q == WLAST) begin
          data_d  = vram_data_in;
          state_d = S_WR;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_WR: begin
        eng_data = data_q;
        if (!cpu_req_in) begin
          eng_we  = 4'b1111;
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == clast_q) ? S_FILL : S_RD;
        end
      end
      S_FILL: begin
        if (!cpu_req_in) begin
          eng_we = 4'b1111;
          if (idx_q == LAST) state_d = S_DONE;
          else idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      clast_q <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      clast_q <= clast_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    if (cpu_req_in) begin
      vram_addr_out         = cpu_addr_in[AW+1:2];
      vram_data_out         = cpu_data_in;
      vram_write_enable_out = cpu_write_enable_in;
    end else begin
      vram_addr_out         = eng_addr;
      vram_data_out         = eng_data;
      vram_write_enable_out = eng_we;
    end
  end

  assign cpu_data_out  = vram_data_in;
  assign cmd_ready_out = state_q == S_IDLE;
  assign busy_out      = state_q != S_IDLE;
  assign done_out      = state_q == S_DONE;

  logic unused_addr;
  assign unused_addr = ^{cpu_addr_in[31:AW+2],
                         cpu_addr_in[1:0]};

endmodule

// File: tb/tb_vram_blit_engine.sv
// Bench for vram_blit_engine: VRAM model, reference write-stream model,
// per-cycle output compare and directed command scenarios.
module tb_vram_blit_engine;
  localparam int CW = 80;
  localparam int RW = 45;
  localparam int AW = 12;
  localparam int LAT = 2;
  localparam int TOTAL = CW * RW;
  localparam int MEMW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_we;
  logic [31:0]   cpu_rdata;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [5:0]    cmd_rows;
  logic [31:0]   cmd_fill;
  logic          busy;
  logic          done;
  logic [AW-1:0] vaddr;
  logic [31:0]   vwdata;
  logic [3:0]    vwe;
  logic [31:0]   vrdata;

  always #5 clk = ~clk;

  vram_blit_engine #(
    .COLS_WORDS(CW), .ROWS(RW),
    .ADDR_WIDTH(AW), .RD_LATENCY(LAT)
  ) dut (
    .clk_in(clk), .rst_in(rst_n),
    .cpu_req_in(cpu_req), .cpu_addr_in(cpu_addr),
    .cpu_data_in(cpu_wdata),
    .cpu_write_enable_in(cpu_we),
    .cpu_data_out(cpu_rdata),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_op_in(cmd_op), .cmd_rows_in(cmd_rows),
    .cmd_fill_in(cmd_fill),
    .busy_out(busy), .done_out(done),
    .vram_addr_out(vaddr), .vram_data_out(vwdata),
    .vram_write_enable_out(vwe),
    .vram_data_in(vrdata)
  );

  logic [31:0] mem [0:MEMW-1];
  logic [31:0] pipe [0:LAT-1];
  logic        load_req = 1'b0;
  logic        load_ramp = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < MEMW; k++)
        mem[k] <= load_ramp ? 32'(k) : 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (vwe[b]) mem[vaddr][8*b +: 8] <= vwdata[8*b +: 8];
    end
    pipe[0] <= mem[vaddr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign vrdata = pipe[LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int wr_seen = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  logic busy_m = 1'b0;
  logic done_due = 1'b0;
  logic [31:0] last5 = 32'h0;
  logic [AW-1:0] qa[$];
  logic [31:0] qd[$];
  logic [31:0] expm [0:TOTAL-1];

  function automatic void chk(string n, logic [31:0] a,
                              logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               n, a, e, cyc);
    end
  endfunction

  // Expected write stream from the buffer as it stands at accept time.
  function automatic void build(logic op, logic [5:0] rows,
                                logic [31:0] fw);
    int r;
    int sh;
    logic [31:0] d;
    r = int'(rows);
    wr_seen = 0;
    qa.delete();
    qd.delete();
    for (int i = 0; i < TOTAL; i++) expm[i] = mem[i];
    if (op && r == 0) return;
    sh = (!op || r >= RW) ? TOTAL : r * CW;
    for (int i = 0; i < TOTAL; i++) begin
      d = (i < TOTAL - sh) ? mem[i + sh] : fw;
      qa.push_back(AW'(i));
      qd.push_back(d);
      expm[i] = d;
    end
  endfunction

  always @(negedge clk) begin
    logic nd;
    logic nb;
    cyc++;
    if (!rst_n) begin
      qa.delete();
      qd.delete();
      busy_m = 1'b0;
      done_due = 1'b0;
    end else begin
      nd = 1'b0;
      nb = busy_m;
      chk("rdata", cpu_rdata, vrdata);
      chk("busy", 32'(busy), 32'(busy_m));
      chk("ready", 32'(cmd_ready), 32'(!busy_m));
      chk("done", 32'(done), 32'(done_due));
      if (cpu_req) begin
        chk("cpu_addr", 32'(vaddr), 32'(cpu_addr[AW+1:2]));
        chk("cpu_wdata", vwdata, cpu_wdata);
        chk("cpu_we", 32'(vwe), 32'(cpu_we));
        if (cpu_we != 4'h0 && cpu_addr[AW+1:2] == AW'(5))
          last5 = cpu_wdata;
      end else if (vwe != 4'h0) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write: got addr %0h want none",
                   vaddr);
        end else begin
          chk("wr_addr", 32'(vaddr), 32'(qa[0]));
          chk("wr_data", vwdata, qd[0]);
          chk("wr_we", 32'(vwe), 32'hF);
          void'(qa.pop_front());
          void'(qd.pop_front());
          wr_seen++;
          if (qa.size() == 0) nd = 1'b1;
        end
      end
      if (done) begin
        nb = 1'b0;
        done_cnt++;
        done_cyc = cyc;
      end
      if (cmd_valid && !busy_m) begin
        acc_cnt++;
        acc_cyc = cyc;
        build(cmd_op, cmd_rows, cmd_fill);
        nb = 1'b1;
        if (cmd_op && cmd_rows == 6'd0) nd = 1'b1;
      end
      done_due = nd;
      busy_m = nb;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic ramp);
    load_ramp = ramp;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [5:0] rows,
                       input logic [31:0] fw);
    int a0;
    a0 = acc_cnt;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_rows = rows;
    cmd_fill = fw;
    step();
    chk("accept", 32'(acc_cnt), 32'(a0 + 1));
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic tog,
                           output int lat);
    int d0;
    int n;
    logic ph;
    d0 = done_cnt;
    n = 0;
    ph = 1'b0;
    while (done_cnt == d0 && n < budget) begin
      if (tog) begin
        ph = !ph;
        cpu_req = ph;
        cpu_we = (ph && n[1]) ? 4'hF : 4'h0;
        cpu_addr = cpu_we != 4'h0 ? 32'd20 : 32'd28;
        cpu_wdata = 32'hC0DE_0000 | 32'(n);
      end
      step();
      n++;
    end
    cpu_req = 1'b0;
    cpu_we = 4'h0;
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got none want done in %0d",
               budget);
    end
    lat = done_cyc - acc_cyc;
  endtask

  task automatic check_mem(input string n, input logic skip5);
    int bad;
    bad = 0;
    for (int i = 0; i < TOTAL; i++)
      if (!(skip5 && i == 5) && mem[i] !== expm[i]) bad++;
    chk(n, 32'(bad), 32'd0);
  endtask

  localparam logic [31:0] F0 = 32'h0720_0720;
  localparam logic [31:0] F1 = 32'h1F41_1F42;
  localparam logic [31:0] F2 = 32'h2E00_2E00;
  localparam logic [31:0] FA = 32'hAAAA_5555;
  localparam logic [31:0] FB = 32'h1234_5678;

  initial begin
    int lat;
    int d0;
    int a0;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_we = '0;
    cmd_valid = 1'b0;
    cmd_op = 1'b0;
    cmd_rows = '0;
    cmd_fill = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(vwe), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    preload(1'b0);
    issue(1'b0, 6'd0, F0);
    wait_done(5000, 1'b0, lat);
    chk("fill_lat", 32'(lat), 32'd3601);
    chk("fill_count", 32'(wr_seen), 32'(TOTAL));
    chk("fill_first", mem[0], F0);
    chk("fill_last", mem[TOTAL-1], F0);
    chk("fill_past_end", mem[TOTAL], 32'h0);
    check_mem("fill_mem", 1'b0);

    preload(1'b1);
    d0 = done_cnt;
    issue(1'b1, 6'd1, F1);
    wait_done(20000, 1'b0, lat);
    repeat (3) step();
    chk("scr1_done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("scr1_lat", 32'(lat), 32'd14161);
    chk("scr1_w0", mem[0], 32'd80);
    chk("scr1_w3519", mem[3519], 32'd3599);
    chk("scr1_w3520", mem[3520], F1);
    chk("scr1_w3599", mem[3599], F1);
    check_mem("scr1_mem", 1'b0);

    preload(1'b1);
    issue(1'b1, 6'd1, F1);
    wait_done(40000, 1'b1, lat);
    chk("tog_slower", 32'(lat > 14161), 32'd1);
    chk("tog_w0", mem[0], 32'd80);
    chk("tog_w5_cpu", mem[5], last5);
    check_mem("tog_mem", 1'b1);

    issue(1'b1, 6'd0, F2);
    wait_done(10, 1'b0, lat);
    chk("rows0_lat", 32'(lat), 32'd1);
    chk("rows0_writes", 32'(wr_seen), 32'd0);
    check_mem("rows0_mem", 1'b0);

    preload(1'b1);
    issue(1'b1, 6'd50, F2);
    wait_done(5000, 1'b0, lat);
    chk("rows50_lat", 32'(lat), 32'd3601);
    chk("rows50_w0", mem[0], F2);
    check_mem("rows50_mem", 1'b0);

    preload(1'b1);
    issue(1'b1, 6'd1, F1);
    for (int n = 0; n < 2000 && wr_seen < 100; n++) step();
    chk("rst_at_100", 32'(wr_seen), 32'd100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_we", 32'(vwe), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (30) step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_w99", mem[99], 32'd179);
    chk("post_rst_w100", mem[100], 32'd100);

    preload(1'b0);
    a0 = acc_cnt;
    cmd_valid = 1'b1;
    cmd_op = 1'b0;
    cmd_fill = FA;
    step();
    cmd_fill = FB;
    wait_done(5000, 1'b0, lat);
    chk("b2b_one_accept", 32'(acc_cnt), 32'(a0 + 1));
    check_mem("b2b_first_mem", 1'b0);
    chk("b2b_first_w0", mem[0], FA);
    step();
    chk("b2b_second", 32'(acc_cnt), 32'(a0 + 2));
    chk("b2b_after_done", 32'(acc_cyc - done_cyc), 32'd1);
    cmd_valid = 1'b0;
    wait_done(5000, 1'b0, lat);
    chk("b2b_second_w0", mem[0], FB);
    check_mem("b2b_second_mem", 1'b0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
